// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped data cache.
package dcache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dcache_state_t;

endpackage

// File: rtl/dcache_line_ram.sv
// Line data storage: LINES x WORDS words, one write port, one combinational read port.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = $clog2(LINES),
    parameter int WORD_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [LINE_W-1:0] i_wr_line,
    input  logic [WORD_W-1:0] i_wr_word,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [LINE_W-1:0] i_rd_line,
    input  logic [WORD_W-1:0] i_rd_word,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [LINES*WORDS];

    // Single write port; contents are don't-care until a line is filled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_line, i_wr_word}] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[{i_rd_line, i_rd_word}];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// single-beat memory handshake. Fills fetch a whole line one word per ack.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accept requests; read hits answered next edge
// ST_FILL  | reading line from memory, one word per memAck
// ST_DONE  | line complete; return requested word to core
// ST_WRITE | write-through of a store to memory, waiting for memAck
module dcache_dm
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dCacheAddr,
    input  logic              dCacheReadEn,
    input  logic              dCacheWriteEn,
    input  logic [DATA_W-1:0] dCacheWriteData,
    output logic [DATA_W-1:0] dCacheReadData,
    output logic              dCacheReadValid,
    output logic              dCacheStall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck
);

    localparam int WORD_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - 2 - WORD_W - IDX_W;

    dcache_state_t     r_state;
    logic [WORD_W-1:0] r_beat;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag [LINES];
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_ack;
    logic              w_fill_last;
    logic [WORD_W-1:0] w_beat_nxt;
    logic              w_ram_we;
    logic [WORD_W-1:0] w_ram_word;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_stall;

    assign w_word      = dCacheAddr[2 +: WORD_W];
    assign w_idx       = dCacheAddr[2 + WORD_W +: IDX_W];
    assign w_tag       = dCacheAddr[ADDR_W-1 -: TAG_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // An ack only counts while a request is outstanding.
    assign w_ack       = memAck && r_mem_req;
    assign w_fill_last = (r_state == ST_FILL) && w_ack && (r_beat == WORD_W'(WORDS - 1));
    assign w_beat_nxt  = r_beat + WORD_W'(1);

    // Line RAM write source: fill beats from memory, or a store that hits in IDLE.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_word  = w_word;
        w_ram_wdata = dCacheWriteData;
        if (rst) begin
            if ((r_state == ST_FILL) && w_ack) begin
                w_ram_we    = 1'b1;
                w_ram_word  = r_beat;
                w_ram_wdata = memRData;
            end else if ((r_state == ST_IDLE) && dCacheWriteEn && w_hit) begin
                w_ram_we    = 1'b1;
            end
        end
    end

    dcache_line_ram #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .DATA_W (DATA_W)
    ) u_line_ram (
        .clk       (clk),
        .i_we      (w_ram_we),
        .i_wr_line (w_idx),
        .i_wr_word (w_ram_word),
        .i_wr_data (w_ram_wdata),
        .i_rd_line (w_idx),
        .i_rd_word (w_word),
        .o_rd_data (w_ram_rdata)
    );

    // Stall: read hits pass through in IDLE; a write releases the core in its ack cycle.
    always_comb begin
        w_stall = 1'b1;
        case (r_state)
            ST_IDLE:  w_stall = dCacheWriteEn || (dCacheReadEn && !w_hit);
            ST_WRITE: w_stall = !w_ack;
            default:  w_stall = 1'b1;
        endcase
    end

    // Tag array is written only when a fill completes; it needs no reset.
    always_ff @(posedge clk) begin
        if (rst && w_fill_last) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    // Controller FSM with registered core/memory outputs and valid bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_valid      <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_read_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dCacheWriteEn) begin
                        r_state     <= ST_WRITE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= dCacheAddr & ~ADDR_W'(3);
                        r_mem_wdata <= dCacheWriteData;
                    end else if (dCacheReadEn) begin
                        if (w_hit) begin
                            r_read_data  <= w_ram_rdata;
                            r_read_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_FILL;
                            r_beat     <= '0;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, WORD_W'(0), 2'b00};
                        end
                    end
                end
                ST_FILL: begin
                    if (w_ack) begin
                        if (w_fill_last) begin
                            r_state        <= ST_DONE;
                            r_beat         <= '0;
                            r_mem_req      <= 1'b0;
                            r_valid[w_idx] <= 1'b1;
                        end else begin
                            r_beat     <= w_beat_nxt;
                            r_mem_addr <= {w_tag, w_idx, w_beat_nxt, 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_read_data  <= w_ram_rdata;
                    r_read_valid <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dCacheReadData  = r_read_data;
    assign dCacheReadValid = r_read_valid;
    assign dCacheStall     = w_stall;
    assign memReq          = r_mem_req;
    assign memWe           = r_mem_we;
    assign memAddr         = r_mem_addr;
    assign memWData        = r_mem_wdata;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a behavioural memory responder.
module tb_dcache_dm;

    logic        clk;
    logic        rst;
    logic [31:0] dCacheAddr;
    logic        dCacheReadEn;
    logic        dCacheWriteEn;
    logic [31:0] dCacheWriteData;
    logic [31:0] dCacheReadData;
    logic        dCacheReadValid;
    logic        dCacheStall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    int n_checks;
    int n_errors;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    bit          burst;
    bit          spurious;

    dcache_dm dut (
        .clk             (clk),
        .rst             (rst),
        .dCacheAddr      (dCacheAddr),
        .dCacheReadEn    (dCacheReadEn),
        .dCacheWriteEn   (dCacheWriteEn),
        .dCacheWriteData (dCacheWriteData),
        .dCacheReadData  (dCacheReadData),
        .dCacheReadValid (dCacheReadValid),
        .dCacheStall     (dCacheStall),
        .memReq          (memReq),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memWData        (memWData),
        .memRData        (memRData),
        .memAck          (memAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'h5A5A, a[15:0]};
    endfunction

    // Memory model: acks every other cycle, or every cycle in burst mode.
    always @(negedge clk) begin
        if (spurious) begin
            memAck = 1'b1;
        end else if (memReq === 1'b1 && (burst || !memAck)) begin
            memAck = 1'b1;
            if (memWe) begin
                mem[memAddr] = memWData;
                wr_addr_q.push_back(memAddr);
                wr_data_q.push_back(memWData);
            end else begin
                memRData = mem_rd(memAddr);
                rd_q.push_back(memAddr);
            end
        end else begin
            memAck = 1'b0;
        end
    end

    task automatic clear_log();
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({memReq, memWe, dCacheReadValid} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got req/we/valid=%b expected 000", {memReq, memWe, dCacheReadValid});
        end
        n_checks++;
        if (dCacheReadData !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h expected 0", dCacheReadData);
        end
        n_checks++;
        if (memAddr !== 32'h0 || memWData !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", memAddr, memWData);
        end
        n_checks++;
        if (dCacheStall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_stall: got %b expected 0", dCacheStall);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                           input bit exp_miss, input logic [31:0] exp_first);
        int cyc;
        bit got;
        bit stall_drop;
        clear_log();
        @(posedge clk); #1;
        dCacheAddr = a; dCacheReadEn = 1'b1; dCacheWriteEn = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (dCacheStall !== exp_miss) begin
            n_errors++;
            $display("FAIL %s stall_first: got %b expected %b", name, dCacheStall, exp_miss);
        end
        cyc = 0; got = 1'b0; stall_drop = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (dCacheReadValid) got = 1'b1;
            else begin
                @(negedge clk); #1;
                if (!dCacheStall) stall_drop = 1'b1;
            end
        end
        dCacheReadEn = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s timeout: got no valid expected valid within 100 cycles", name);
        end
        n_checks++;
        if (dCacheReadData !== exp) begin
            n_errors++;
            $display("FAIL %s data: got %h expected %h", name, dCacheReadData, exp);
        end
        if (exp_miss) begin
            n_checks++;
            if (stall_drop) begin
                n_errors++;
                $display("FAIL %s stall_fill: got stall low expected high during fill", name);
            end
            n_checks++;
            if (rd_q.size() != 4) begin
                n_errors++;
                $display("FAIL %s beats: got %0d expected 4", name, rd_q.size());
            end
            for (int i = 0; i < 4; i++) begin
                if (rd_q.size() > i) begin
                    n_checks++;
                    if (rd_q[i] !== exp_first + 32'(4 * i)) begin
                        n_errors++;
                        $display("FAIL %s beat_addr%0d: got %h expected %h", name, i, rd_q[i], exp_first + 32'(4 * i));
                    end
                end
            end
        end else begin
            n_checks++;
            if (cyc != 1 || rd_q.size() != 0) begin
                n_errors++;
                $display("FAIL %s hit: got latency=%0d reads=%0d expected 1/0", name, cyc, rd_q.size());
            end
        end
        n_checks++;
        if (wr_addr_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s no_write: got %0d writes expected 0", name, wr_addr_q.size());
        end
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d, input bit also_read);
        int cyc;
        bit done;
        bit saw_valid;
        clear_log();
        @(posedge clk); #1;
        dCacheAddr = a; dCacheWriteData = d; dCacheWriteEn = 1'b1; dCacheReadEn = also_read;
        @(negedge clk); #1;
        n_checks++;
        if (dCacheStall !== 1'b1) begin
            n_errors++;
            $display("FAIL %s stall_first: got %b expected 1", name, dCacheStall);
        end
        cyc = 0; done = 1'b0; saw_valid = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            if (dCacheReadValid) saw_valid = 1'b1;
            if (!dCacheStall) done = 1'b1;
        end
        @(posedge clk); #1;
        dCacheWriteEn = 1'b0; dCacheReadEn = 1'b0;
        if (dCacheReadValid) saw_valid = 1'b1;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s timeout: got stall stuck expected release within 100 cycles", name);
        end
        n_checks++;
        if (wr_addr_q.size() != 1 || rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s count: got writes=%0d reads=%0d expected 1/0", name, wr_addr_q.size(), rd_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== a || wr_data_q[0] !== d) begin
                n_errors++;
                $display("FAIL %s mem_write: got %h=%h expected %h=%h", name, wr_addr_q[0], wr_data_q[0], a, d);
            end
        end
        n_checks++;
        if (saw_valid || memReq !== 1'b0) begin
            n_errors++;
            $display("FAIL %s after: got valid_seen=%b memReq=%b expected 0/0", name, saw_valid, memReq);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        @(posedge clk); #1;
        dCacheAddr = 32'h44; dCacheReadEn = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (dCacheStall !== 1'b0 || memReq !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_first: got stall=%b memReq=%b expected 0/0", dCacheStall, memReq);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dCacheReadValid !== 1'b1 || dCacheReadData !== 32'hA1) begin
            n_errors++;
            $display("FAIL b2b_data0: got v=%b d=%h expected 1/000000a1", dCacheReadValid, dCacheReadData);
        end
        dCacheAddr = 32'h48;
        @(negedge clk); #1;
        n_checks++;
        if (dCacheStall !== 1'b0 || memReq !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_second: got stall=%b memReq=%b expected 0/0", dCacheStall, memReq);
        end
        @(posedge clk); #1;
        n_checks++;
        if (dCacheReadValid !== 1'b1 || dCacheReadData !== 32'hA2) begin
            n_errors++;
            $display("FAIL b2b_data1: got v=%b d=%h expected 1/000000a2", dCacheReadValid, dCacheReadData);
        end
        dCacheReadEn = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dCacheReadValid !== 1'b0 || rd_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_idle: got v=%b reads=%0d expected 0/0", dCacheReadValid, rd_q.size());
        end
    endtask

    task automatic test_spurious_ack();
        @(posedge clk); #1;
        spurious = 1'b1;
        @(posedge clk); #1;
        spurious = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (memReq !== 1'b0 || dCacheReadValid !== 1'b0 || dCacheStall !== 1'b0) begin
            n_errors++;
            $display("FAIL spurious_ack: got req=%b valid=%b stall=%b expected 0/0/0", memReq, dCacheReadValid, dCacheStall);
        end
    endtask

    task automatic test_reset_fill();
        int cyc;
        clear_log();
        @(posedge clk); #1;
        dCacheAddr = 32'h80; dCacheReadEn = 1'b1;
        cyc = 0;
        while (rd_q.size() < 2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (rd_q.size() < 2) begin
            n_errors++;
            $display("FAIL rstfill_wait: got %0d beats expected 2", rd_q.size());
        end
        rst = 1'b0; dCacheReadEn = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_checks++;
        if (memReq !== 1'b0) begin
            n_errors++;
            $display("FAIL rstfill_req: got %b expected 0", memReq);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (memReq !== 1'b0 || rd_q.size() != 2) begin
            n_errors++;
            $display("FAIL rstfill_quiet: got req=%b beats=%0d expected 0/2", memReq, rd_q.size());
        end
        do_read("rd_80_refill", 32'h80, 32'h5A5A0080, 1'b1, 32'h80);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        burst = 1'b0; spurious = 1'b0;
        memAck = 1'b0; memRData = '0;
        rst = 1'b0;
        dCacheAddr = '0; dCacheReadEn = 1'b0; dCacheWriteEn = 1'b0; dCacheWriteData = '0;
        mem[32'h40] = 32'hA0; mem[32'h44] = 32'hA1;
        mem[32'h48] = 32'hA2; mem[32'h4C] = 32'hA3;

        test_reset();
        do_read("rd_40_miss", 32'h40, 32'hA0, 1'b1, 32'h40);
        test_back_to_back();
        do_write("wr_44_hit", 32'h44, 32'hDEADBEEF, 1'b0);
        do_read("rd_44_hit", 32'h44, 32'hDEADBEEF, 1'b0, 32'h0);
        do_write("wr_1000_miss", 32'h1000, 32'h1234, 1'b0);
        do_read("rd_1000_miss", 32'h1000, 32'h1234, 1'b1, 32'h1000);
        do_write("wr_48_both_en", 32'h48, 32'h55, 1'b1);
        do_read("rd_48_hit", 32'h48, 32'h55, 1'b0, 32'h0);
        test_spurious_ack();
        do_read("rd_40_hit", 32'h40, 32'hA0, 1'b0, 32'h0);
        burst = 1'b1;
        do_read("rd_440_evict", 32'h440, 32'h5A5A0440, 1'b1, 32'h440);
        burst = 1'b0;
        do_read("rd_40_refill", 32'h40, 32'hA0, 1'b1, 32'h40);
        do_read("rd_44_refill_hit", 32'h44, 32'hDEADBEEF, 1'b0, 32'h0);
        test_reset_fill();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1);
    end

endmodule
